edge_generator: RTL and testbench
=================================

EDGE_GENERATOR -- requirements
Module: edge_generator

Interface
REQ-001 Parameter HOLD_W, default 8, width of the per-request hold count.
REQ-002 Parameter CNT_W, default 16, width of the transition counter.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, level of sig_out after reset.
REQ-004 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port req_valid  input  1  request present.
REQ-007 Port req_ready  output  1  block can accept a request.
REQ-008 Port req_kind  input  2  request kind: WAIT=0, RISE=1, FALL=2, TOGGLE=3.
REQ-009 Port req_hold  input  HOLD_W  extra cycles the resulting level is held.
REQ-010 Port sig_out  output  1  generated waveform, driven directly from a flop.
REQ-011 Port done  output  1  one-cycle pulse when a request's hold period ends.
REQ-012 Port redundant  output  1  one-cycle pulse for a RISE/FALL that causes no transition.
REQ-013 Port edge_cnt  output  CNT_W  count of transitions actually driven on sig_out.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-015 req_ready SHALL be 1 exactly when the state is IDLE; it SHALL NOT depend combinationally on req_valid.
REQ-016 A request SHALL be accepted on a rising clk edge where req_valid and req_ready are both 1; req_kind and req_hold are sampled only at that edge.
REQ-017 Target level on acceptance: RISE gives 1, FALL gives 0, TOGGLE gives ~sig_out, and WAIT gives sig_out.
REQ-018 sig_out SHALL take the target level at the accepting edge, so the change is visible one cycle after the handshake.
REQ-019 edge_cnt SHALL increment by 1 at the accepting edge only when the target level differs from sig_out; it SHALL wrap from 2^CNT_W-1 to 0.
REQ-020 On acceptance the FSM SHALL enter HOLD and load the hold counter with req_hold.
REQ-021 In HOLD with counter > 0, the counter SHALL decrement by 1 each cycle.
REQ-022 In HOLD with counter == 0, the next edge SHALL return the FSM to IDLE and assert done for exactly that following cycle.
REQ-023 Minimum level width: every sig_out level SHALL persist at least req_hold+2 cycles, so a 2-flop edge detector downstream observes every transition.
REQ-024 redundant SHALL pulse for one cycle after acceptance of RISE while sig_out=1 or FALL while sig_out=0; the request is otherwise processed as a WAIT.
REQ-025 WAIT and TOGGLE SHALL never assert redundant.
REQ-026 req_valid, req_kind and req_hold SHALL be ignored while in HOLD, with no state change.
REQ-027 With req_hold=0, a back-to-back request stream SHALL be accepted every 2 cycles.
REQ-028 req_valid held high in IDLE on the cycle done pulses SHALL be accepted at that edge.

Reset
REQ-029 While rst_n=0 the block SHALL hold: state IDLE, sig_out=IDLE_LEVEL, hold counter 0, edge_cnt 0, done 0, redundant 0, req_ready 1.
REQ-030 Reset asserted mid-HOLD SHALL abort the request immediately, with no done pulse.
REQ-031 The first request SHALL be accepted no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-032 Package edge_gen_pkg SHALL define the enum edge_kind_e {EK_WAIT, EK_RISE, EK_FALL, EK_TOGGLE} and the FSM state enum.
REQ-033 The down-counter SHALL be a sub-module hold_timer (load, load value, zero flag), parameterised by HOLD_W.
REQ-034 All outputs SHALL be registered except req_ready, which decodes the registered state.

Verification
REQ-035 Reset with IDLE_LEVEL=0, then RISE with hold=3: sig_out reads 1 one cycle after the handshake; done pulses 5 cycles after the handshake; edge_cnt=1.
REQ-036 Reset, then TOGGLE x4 with hold=0 and req_valid held high: sig_out reads 1,0,1,0, each level lasting exactly 2 cycles; edge_cnt=4; four done pulses.
REQ-037 Reset, then FALL with sig_out=0: redundant pulses once, sig_out stays 0, edge_cnt stays 0, done still pulses.
REQ-038 RISE with hold=200, then rst_n=0 at cycle 50: sig_out=0, req_ready=1 and edge_cnt=0 immediately (asynchronously); no done pulse.
REQ-039 CNT_W=4: 17 TOGGLEs give edge_cnt=1 (wrap confirmed).
REQ-040 Loopback of sig_out through a 2-flop edge detector, with random kinds and holds from 0 to 5: detected edge count equals edge_cnt, and no edge is missed.

Source files
------------

// File: rtl/edge_gen_pkg.sv
// Shared types and decode helpers for the edge generator.
package edge_gen_pkg;

    typedef enum logic [1:0] {
        EK_WAIT   = 2'd0,
        EK_RISE   = 2'd1,
        EK_FALL   = 2'd2,
        EK_TOGGLE = 2'd3
    } edge_kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Level sig_out should take when a request of this kind is accepted.
    function automatic logic target_level(input edge_kind_e kind, input logic cur);
        logic lvl;
        lvl = cur;
        case (kind)
            EK_WAIT:   lvl = cur;
            EK_RISE:   lvl = 1'b1;
            EK_FALL:   lvl = 1'b0;
            EK_TOGGLE: lvl = ~cur;
            default:   lvl = cur;
        endcase
        return lvl;
    endfunction

    // A RISE onto a high line or a FALL onto a low line changes nothing.
    function automatic logic is_redundant(input edge_kind_e kind, input logic cur);
        return ((kind == EK_RISE) && cur) || ((kind == EK_FALL) && !cur);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that stops at zero; times the hold period of a request.
module hold_timer #(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [HOLD_W-1:0] i_load_val,
    output logic              o_zero_c
);

    logic [HOLD_W-1:0] r_count;

    // Load on request acceptance, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - HOLD_W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/edge_generator.sv
// Request-driven waveform generator with a guaranteed minimum level width.
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int unsigned HOLD_W     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              sig_out,
    output logic              done,
    output logic              redundant,
    output logic [CNT_W-1:0]  edge_cnt
);

    state_e           r_state;
    logic             r_sig;
    logic             r_done;
    logic             r_redundant;
    logic [CNT_W-1:0] r_edge_cnt;

    edge_kind_e w_kind;
    logic       w_accept;
    logic       w_target;
    logic       w_redundant;
    logic       w_zero;

    assign w_kind      = edge_kind_e'(req_kind);
    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_target    = target_level(w_kind, r_sig);
    assign w_redundant = is_redundant(w_kind, r_sig);

    hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (req_hold),
        .o_zero_c   (w_zero)
    );

    // Accept in IDLE, drive the new level, then wait out the hold in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sig       <= IDLE_LEVEL;
            r_done      <= 1'b0;
            r_redundant <= 1'b0;
            r_edge_cnt  <= '0;
        end else begin
            r_done      <= 1'b0;
            r_redundant <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_HOLD;
                        r_sig       <= w_target;
                        r_redundant <= w_redundant;
                        if (w_target != r_sig) begin
                            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_zero) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign sig_out   = r_sig;
    assign done      = r_done;
    assign redundant = r_redundant;
    assign edge_cnt  = r_edge_cnt;

endmodule

// File: tb/tb_edge_generator.sv
// Directed, table-driven bench for edge_generator.
module tb_edge_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [7:0]  req_hold;
    logic        sig_out;
    logic        done;
    logic        redundant;
    logic [15:0] edge_cnt;

    logic        req_valid4;
    logic        req_ready4;
    logic [1:0]  req_kind4;
    logic [7:0]  req_hold4;
    logic        sig_out4;
    logic        done4;
    logic        redundant4;
    logic [3:0]  edge_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    logic d1, d2;
    int   det;

    always #5 clk = ~clk;

    edge_generator #(.HOLD_W(8), .CNT_W(16), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_hold  (req_hold),
        .sig_out   (sig_out),
        .done      (done),
        .redundant (redundant),
        .edge_cnt  (edge_cnt)
    );

    edge_generator #(.HOLD_W(8), .CNT_W(4), .IDLE_LEVEL(1'b0)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid4),
        .req_ready (req_ready4),
        .req_kind  (req_kind4),
        .req_hold  (req_hold4),
        .sig_out   (sig_out4),
        .done      (done4),
        .redundant (redundant4),
        .edge_cnt  (edge_cnt4)
    );

    // Downstream 2-flop edge detector on sig_out.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1  <= 1'b0;
            d2  <= 1'b0;
            det <= 0;
        end else begin
            d1 <= sig_out;
            d2 <= d1;
            if (d1 != d2) det <= det + 1;
        end
    end

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  hold;
        logic        exp_sig;
        logic        exp_red;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_valid4 = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Issue one request, check its immediate effect, then track it to done.
    task automatic do_req(input string tag, input logic [1:0] k, input logic [7:0] h,
                          input logic exp_sig, input logic exp_red, input logic [15:0] exp_cnt);
        int   lat;
        logic seen;
        chk({tag, "_ready_before"}, req_ready, 1);
        req_valid = 1'b1;
        req_kind  = k;
        req_hold  = h;
        step();
        req_valid = 1'b0;
        chk({tag, "_sig"}, sig_out, exp_sig);
        chk({tag, "_red"}, redundant, exp_red);
        chk({tag, "_cnt"}, edge_cnt, exp_cnt);
        chk({tag, "_busy"}, req_ready, 0);
        chk({tag, "_nodone1"}, done, 0);
        lat  = 1;
        seen = 1'b0;
        while (lat < 300) begin
            req_valid = 1'($urandom_range(0, 1));
            req_kind  = 2'($urandom_range(0, 3));
            req_hold  = 8'($urandom_range(0, 255));
            step();
            lat++;
            if (lat == 2) chk({tag, "_red_pulse"}, redundant, 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) chk({tag, "_done_lat"}, lat, 32'(h) + 2);
        chk({tag, "_sig_held"}, sig_out, exp_sig);
        chk({tag, "_cnt_held"}, edge_cnt, exp_cnt);
        step();
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_ready_after"}, req_ready, 1);
    endtask

    initial begin
        int          ndone;
        logic        m_sig;
        logic        m_red;
        logic [15:0] m_cnt;
        logic [1:0]  k;
        logic [7:0]  h;
        logic [7:0]  exp_sig_seq;
        logic [7:0]  exp_done_seq;

        vecs[0] = '{2'd1, 8'd3,   1'b1, 1'b0, 16'd1};
        vecs[1] = '{2'd1, 8'd0,   1'b1, 1'b1, 16'd1};
        vecs[2] = '{2'd0, 8'd2,   1'b1, 1'b0, 16'd1};
        vecs[3] = '{2'd3, 8'd1,   1'b0, 1'b0, 16'd2};
        vecs[4] = '{2'd2, 8'd0,   1'b0, 1'b1, 16'd2};
        vecs[5] = '{2'd2, 8'd4,   1'b0, 1'b1, 16'd2};
        vecs[6] = '{2'd3, 8'd0,   1'b1, 1'b0, 16'd3};
        vecs[7] = '{2'd2, 8'd5,   1'b0, 1'b0, 16'd4};
        vecs[8] = '{2'd0, 8'd0,   1'b0, 1'b0, 16'd4};
        vecs[9] = '{2'd1, 8'd255, 1'b1, 1'b0, 16'd5};

        req_valid  = 1'b0;
        req_kind   = 2'd0;
        req_hold   = 8'd0;
        req_valid4 = 1'b0;
        req_kind4  = 2'd0;
        req_hold4  = 8'd0;
        rst_n      = 1'b0;

        // Values while reset is held.
        step();
        chk("rst_sig", sig_out, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_cnt", edge_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_red", redundant, 0);
        rst_n = 1'b1;

        // Redundant FALL straight out of reset.
        do_req("fall0", 2'd2, 8'd0, 1'b0, 1'b1, 16'd0);

        // Table of single requests from a fresh reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].kind, vecs[i].hold,
                   vecs[i].exp_sig, vecs[i].exp_red, vecs[i].exp_cnt);
        end

        // Back-to-back TOGGLE x4, hold 0, valid held high.
        exp_sig_seq  = 8'b0011_0011;
        exp_done_seq = 8'b1010_1010;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_kind  = 2'd3;
        req_hold  = 8'd0;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("b2b_sig_c%0d", c), sig_out, exp_sig_seq[c-1]);
            chk($sformatf("b2b_done_c%0d", c), done, exp_done_seq[c-1]);
            if (c == 8) req_valid = 1'b0;
        end
        step();
        chk("b2b_cnt", edge_cnt, 4);
        chk("b2b_sig_end", sig_out, 0);
        chk("b2b_ready_end", req_ready, 1);

        // Asynchronous reset in the middle of a long hold.
        do_reset();
        req_valid = 1'b1;
        req_kind  = 2'd1;
        req_hold  = 8'd200;
        step();
        req_valid = 1'b0;
        for (int c = 2; c <= 50; c++) step();
        chk("abort_pre_sig", sig_out, 1);
        chk("abort_pre_busy", req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_sig", sig_out, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_cnt", edge_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 210; c++) begin
            step();
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_idle_ready", req_ready, 1);

        // 4-bit counter wrap after 17 toggles.
        do_reset();
        req_valid4 = 1'b1;
        req_kind4  = 2'd3;
        req_hold4  = 8'd0;
        ndone      = 0;
        for (int c = 1; c <= 34; c++) begin
            step();
            if (done4) ndone++;
            if (c == 34) req_valid4 = 1'b0;
        end
        step();
        chk("wrap_cnt", edge_cnt4, 1);
        chk("wrap_done_count", ndone, 17);
        chk("wrap_sig", sig_out4, 1);

        // Random loopback through the edge detector.
        do_reset();
        m_sig = 1'b0;
        m_cnt = 16'd0;
        for (int i = 0; i < 40; i++) begin
            k     = 2'($urandom_range(0, 3));
            h     = 8'($urandom_range(0, 5));
            m_red = (k == 2'd1 && m_sig) || (k == 2'd2 && !m_sig);
            case (k)
                2'd1:    begin if (!m_sig) m_cnt++; m_sig = 1'b1; end
                2'd2:    begin if (m_sig)  m_cnt++; m_sig = 1'b0; end
                2'd3:    begin m_cnt++; m_sig = ~m_sig; end
                default: ;
            endcase
            do_req($sformatf("rnd%0d", i), k, h, m_sig, m_red, m_cnt);
        end
        step();
        step();
        step();
        chk("loop_det_vs_cnt", det, 32'(edge_cnt));
        chk("loop_det_vs_model", det, 32'(m_cnt));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
